// File: rtl/i2s_rx_capture_pkg.sv
// Shared definitions for the I2S receive path: capture FSM encoding,
// default sample width and synchronizer depth.
package i2s_rx_capture_pkg;

  localparam int DEF_SAMPLE_WIDTH = 16;
  localparam int SYNC_DEPTH       = 2;

  typedef enum logic [1:0] {
    ST_WAIT_SYNC = 2'd0,
    ST_DELAY     = 2'd1,
    ST_SHIFT     = 2'd2
  } cap_state_t;

endpackage

// File: rtl/i2s_rx_capture_edge_sync.sv
// Three-flop synchronizer for an asynchronous clock-like input, producing
// single-cycle rise and fall pulses in the clk domain.
module edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [2:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[1:0], i_async};
    end
  end

  assign o_rise = r_sync[1] & ~r_sync[2];
  assign o_fall = ~r_sync[1] & r_sync[2];

endmodule

// File: rtl/i2s_rx_capture.sv
// I2S ADC capture into a one-frame holding register, read out by the RPi
// over a clocked three-wire link (RPi drives clock and enable).
module i2s_rx_capture
  import i2s_rx_capture_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic i2s_bclk,
  input  logic i2s_lrclk,
  input  logic i2s_sdin,
  input  logic rpi_clk,
  input  logic rpi_enable,
  output logic rpi_serial,
  output logic rpi_interrupt,
  output logic overrun
);

  localparam int FW = 2 * SAMPLE_WIDTH;
  localparam int CW = $clog2(SAMPLE_WIDTH + 1);
  localparam int RW = $clog2(FW);

  logic                    w_bclk_rise, w_unused_bclk_fall;
  logic                    w_rclk_fall, w_unused_rclk_rise;
  logic [SYNC_DEPTH-1:0]   r_lr_sync, r_sd_sync, r_en_sync;
  logic                    w_lr, w_sd, w_en, w_en_rise;

  cap_state_t              r_state;
  logic                    r_lr_prev;
  logic [CW-1:0]           r_cnt;
  logic [SAMPLE_WIDTH-1:0] r_word, r_left, w_closed;
  logic                    w_commit;
  logic [FW-1:0]           w_frame;

  logic [FW-1:0]           r_hold, r_rd_sh;
  logic                    r_full, r_ovr, r_rd_act, r_serial, r_en_prev;
  logic [RW-1:0]           r_rd_cnt;
  logic                    w_load, w_step, w_done;

  edge_sync u_bclk_sync (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_async (i2s_bclk),
    .o_rise  (w_bclk_rise),
    .o_fall  (w_unused_bclk_fall)
  );

  edge_sync u_rclk_sync (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_async (rpi_clk),
    .o_rise  (w_unused_rclk_rise),
    .o_fall  (w_rclk_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lr_sync <= '0;
      r_sd_sync <= '0;
      r_en_sync <= '0;
    end else begin
      r_lr_sync <= {r_lr_sync[SYNC_DEPTH-2:0], i2s_lrclk};
      r_sd_sync <= {r_sd_sync[SYNC_DEPTH-2:0], i2s_sdin};
      r_en_sync <= {r_en_sync[SYNC_DEPTH-2:0], rpi_enable};
    end
  end

  assign w_lr      = r_lr_sync[SYNC_DEPTH-1];
  assign w_sd      = r_sd_sync[SYNC_DEPTH-1];
  assign w_en      = r_en_sync[SYNC_DEPTH-1];
  assign w_en_rise = w_en & ~r_en_prev;

  // Short words are left-justified so the missing LSBs read as zero.
  assign w_closed = r_word << (CW'(SAMPLE_WIDTH) - r_cnt);
  assign w_commit = (r_state == ST_SHIFT) & w_bclk_rise & r_lr_prev & ~w_lr;
  assign w_frame  = {r_left, w_closed};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_WAIT_SYNC;
      r_lr_prev <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        ST_WAIT_SYNC: if (w_bclk_rise) begin
          r_lr_prev <= w_lr;
          if (r_lr_prev && !w_lr) r_state <= ST_DELAY;
        end
        ST_DELAY: begin
          r_cnt   <= '0;
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: if (w_bclk_rise) begin
          r_lr_prev <= w_lr;
          if (w_lr != r_lr_prev)                r_cnt <= '0;
          else if (r_cnt < CW'(SAMPLE_WIDTH))   r_cnt <= r_cnt + 1'b1;
        end
        default: r_state <= ST_WAIT_SYNC;
      endcase
    end
  end

  assign w_load = w_en_rise & r_full & ~r_rd_act;
  assign w_step = r_rd_act & w_en & w_rclk_fall;
  assign w_done = w_step & (r_rd_cnt == RW'(FW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full    <= 1'b0;
      r_ovr     <= 1'b0;
      r_rd_act  <= 1'b0;
      r_rd_cnt  <= '0;
      r_serial  <= 1'b0;
      r_en_prev <= 1'b0;
    end else begin
      r_en_prev <= w_en;
      if (r_rd_act && !w_en) begin
        r_rd_act <= 1'b0;
        r_serial <= 1'b0;
      end else if (w_load) begin
        r_rd_act <= 1'b1;
        r_rd_cnt <= '0;
        r_serial <= r_hold[FW-1];
      end else if (w_step) begin
        if (w_done) begin
          r_rd_act <= 1'b0;
          r_serial <= 1'b0;
        end else begin
          r_serial <= r_rd_sh[FW-1];
          r_rd_cnt <= r_rd_cnt + 1'b1;
        end
      end
      // A completion in the same cycle frees the slot for the incoming frame.
      if (w_commit) begin
        if (r_full && !w_done) r_ovr  <= 1'b1;
        else                   r_full <= 1'b1;
      end else if (w_done) begin
        r_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_DELAY) begin
      r_word <= '0;
    end else if (r_state == ST_SHIFT && w_bclk_rise) begin
      if (w_lr != r_lr_prev) begin
        r_word <= '0;
        if (w_lr) r_left <= w_closed;
      end else if (r_cnt < CW'(SAMPLE_WIDTH)) begin
        r_word <= {r_word[SAMPLE_WIDTH-2:0], w_sd};
      end
    end
    if (w_commit && (!r_full || w_done)) r_hold <= w_frame;
    if (w_load)      r_rd_sh <= {r_hold[FW-2:0], 1'b0};
    else if (w_step) r_rd_sh <= {r_rd_sh[FW-2:0], 1'b0};
  end

  assign rpi_serial    = r_serial;
  assign rpi_interrupt = r_full;
  assign overrun       = r_ovr;

endmodule

// File: tb/tb_i2s_rx_capture.sv
// Randomized bench for i2s_rx_capture: an I2S ADC driver logs every bit it
// sends, and a run-based decoder turns that log into the expected frames.
module tb_i2s_rx_capture;

  localparam int W = 16;

  logic clk = 1'b0, rst = 1'b1;
  logic i2s_bclk = 1'b0, i2s_lrclk = 1'b0, i2s_sdin = 1'b0;
  logic rpi_clk = 1'b0, rpi_enable = 1'b0;
  logic rpi_serial, rpi_interrupt, overrun;

  int n_chk = 0;
  int n_err = 0;

  bit              log_lr[$];
  bit              log_d[$];
  logic [2*W-1:0]  mdl_frames[$];

  i2s_rx_capture #(.SAMPLE_WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .i2s_bclk      (i2s_bclk),
    .i2s_lrclk     (i2s_lrclk),
    .i2s_sdin      (i2s_sdin),
    .rpi_clk       (rpi_clk),
    .rpi_enable    (rpi_enable),
    .rpi_serial    (rpi_serial),
    .rpi_interrupt (rpi_interrupt),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i2s_bclk = 1'b0; i2s_lrclk = 1'b0; i2s_sdin = 1'b0;
    rpi_clk = 1'b0; rpi_enable = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    log_lr.delete();
    log_d.delete();
    wait_clk(3);
  endtask

  // One bclk period of 16 clk; data and lrclk change while bclk is low.
  task automatic send_bit(input bit lr, input bit d);
    i2s_lrclk = lr;
    i2s_sdin  = d;
    wait_clk(8);
    i2s_bclk = 1'b1;
    log_lr.push_back(lr);
    log_d.push_back(d);
    wait_clk(8);
    i2s_bclk = 1'b0;
  endtask

  // Delay slot (random data) followed by n data bits, MSB first.
  task automatic send_word(input bit lr, input logic [31:0] val, input int n);
    send_bit(lr, 1'($urandom));
    for (int i = n - 1; i >= 0; i--) send_bit(lr, val[i]);
  endtask

  function automatic logic [W-1:0] extract(input int s, input int len);
    logic [W-1:0] w;
    w = '0;
    for (int b = 0; b < W; b++)
      if (b < len - 1) w[W-1-b] = log_d[s+1+b];
    return w;
  endfunction

  // Split the log into runs of constant lrclk; capture starts at the first
  // left run that follows a right run, and a pair commits once another run
  // begins after its right run.
  task automatic decode();
    int rs[$];
    int rl[$];
    bit rlr[$];
    int k;
    mdl_frames.delete();
    for (int i = 0; i < log_lr.size(); i++) begin
      if (i == 0 || log_lr[i] != log_lr[i-1]) begin
        rs.push_back(i);
        rl.push_back(1);
        rlr.push_back(log_lr[i]);
      end else begin
        rl[rl.size()-1] = rl[rl.size()-1] + 1;
      end
    end
    k = -1;
    for (int j = 1; j < rs.size(); j++)
      if (k < 0 && rlr[j] == 1'b0) k = j;
    if (k >= 0)
      for (int j = k; j + 2 < rs.size(); j += 2)
        mdl_frames.push_back({extract(rs[j], rl[j]), extract(rs[j+1], rl[j+1])});
  endtask

  task automatic read_frame(input int nbits, input bit drop, output logic [31:0] got);
    got = '0;
    rpi_enable = 1'b1;
    wait_clk(5);
    for (int i = 0; i < nbits; i++) begin
      got = {got[30:0], rpi_serial};
      rpi_clk = 1'b1;
      wait_clk(4);
      rpi_clk = 1'b0;
      wait_clk(5);
    end
    if (drop) begin
      rpi_enable = 1'b0;
      wait_clk(5);
    end
  endtask

  task automatic run_case(input string tag, output logic [31:0] got);
    decode();
    got = '0;
    chk({tag, "_irq"}, 64'(rpi_interrupt), 64'(mdl_frames.size() > 0));
    chk({tag, "_ovr"}, 64'(overrun), 64'(mdl_frames.size() > 1));
    if (mdl_frames.size() > 0) begin
      read_frame(2 * W, 1'b0, got);
      chk({tag, "_frame"}, 64'(got), 64'(mdl_frames[0]));
      chk({tag, "_irq_done"}, 64'(rpi_interrupt), 64'd0);
      chk({tag, "_ser_done"}, 64'(rpi_serial), 64'd0);
      rpi_enable = 1'b0;
      wait_clk(5);
    end
  endtask

  task automatic garbage(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1, 1'($urandom));
  endtask

  initial begin
    logic [31:0] got;
    logic [15:0] l, r;

    wait_clk(2);
    chk("rst_serial", 64'(rpi_serial), 64'd0);
    chk("rst_irq", 64'(rpi_interrupt), 64'd0);
    chk("rst_ovr", 64'(overrun), 64'd0);
    do_reset();

    garbage(3);
    send_word(1'b0, 32'hA5C3, W);
    send_word(1'b1, 32'h1234, W);
    send_bit(1'b0, 1'b0);
    run_case("basic", got);
    chk("basic_const", 64'(got), 64'hA5C31234);
    rpi_enable = 1'b1;
    wait_clk(5);
    rpi_clk = 1'b1; wait_clk(4); rpi_clk = 1'b0; wait_clk(5);
    chk("empty_ser", 64'(rpi_serial), 64'd0);
    rpi_enable = 1'b0;
    wait_clk(5);

    do_reset();
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b1);
    send_word(1'b0, 32'h0001, W);
    send_word(1'b1, 32'h0002, W);
    send_bit(1'b0, 1'b0);
    run_case("presync", got);
    chk("presync_const", 64'(got), 64'h00010002);

    do_reset();
    garbage(2);
    for (int f = 0; f < 2; f++) begin
      send_word(1'b0, $urandom, W);
      send_word(1'b1, $urandom, W);
    end
    send_bit(1'b0, 1'b0);
    run_case("overrun", got);

    do_reset();
    garbage(2);
    send_word(1'b0, $urandom, W);
    send_word(1'b1, $urandom, W);
    send_bit(1'b0, 1'b0);
    decode();
    read_frame(10, 1'b1, got);
    chk("abort_bits", 64'(got[9:0]), 64'(mdl_frames[0][31:22]));
    chk("abort_irq", 64'(rpi_interrupt), 64'd1);
    run_case("abort", got);

    do_reset();
    r = 16'($urandom);
    garbage(1);
    send_word(1'b0, 32'hABC, 12);
    send_word(1'b1, 32'(r), W);
    send_bit(1'b0, 1'b0);
    run_case("short", got);
    chk("short_const", 64'(got), 64'({16'hABC0, r}));

    do_reset();
    garbage(2);
    send_word(1'b0, $urandom, W);
    send_word(1'b1, $urandom, W);
    send_bit(1'b0, 1'b0);
    read_frame(20, 1'b0, got);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_serial", 64'(rpi_serial), 64'd0);
    chk("midrst_irq", 64'(rpi_interrupt), 64'd0);
    chk("midrst_ovr", 64'(overrun), 64'd0);
    wait_clk(2);
    rpi_enable = 1'b0;
    wait_clk(1);
    rst = 1'b0;
    log_lr.delete();
    log_d.delete();
    wait_clk(3);
    l = 16'($urandom);
    r = 16'($urandom);
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'($urandom));
    send_word(1'b1, $urandom, W);
    send_word(1'b0, 32'(l), W);
    send_word(1'b1, 32'(r), W);
    send_bit(1'b0, 1'b0);
    run_case("resync", got);
    chk("resync_const", 64'(got), 64'({l, r}));

    for (int it = 0; it < 4; it++) begin
      int nf;
      do_reset();
      garbage($urandom_range(1, 5));
      nf = $urandom_range(1, 2);
      for (int f = 0; f < nf; f++) begin
        send_word(1'b0, $urandom, $urandom_range(8, 18));
        send_word(1'b1, $urandom, $urandom_range(8, 18));
      end
      send_bit(1'b0, 1'b0);
      run_case($sformatf("rand%0d", it), got);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/i2s_rx_capture.md
# i2s_rx_capture

I2S receive path, the return direction of the existing RPi→DAC playback chain. Captures stereo samples from an external I2S ADC (ADC is bit-clock/word-clock master), packs each left/right pair into a one-frame holding register, raises `rpi_interrupt`, and serializes the frame to the Raspberry Pi over the same three-wire clocked link style the playback input uses (RPi drives clock and enable; this block drives data). Sits beside the playback path in `top`, clocked from the divided system clock.

## Interface
- `SAMPLE_WIDTH`, 16, bits captured per channel; frame on RPi link is 2×`SAMPLE_WIDTH`.
- `clk` in 1: system clock (`main_clk[3]` in `top`); all logic on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `i2s_bclk` in 1: ADC bit clock, async to `clk`, frequency ≤ `clk`/8.
- `i2s_lrclk` in 1: ADC word clock; 0 = left, 1 = right.
- `i2s_sdin` in 1: ADC serial data, MSB first, valid on `i2s_bclk` rise.
- `rpi_clk` in 1: RPi link clock, async, ≤ `clk`/8.
- `rpi_enable` in 1: RPi transfer select, active-high.
- `rpi_serial` out 1: frame data to RPi, MSB first.
- `rpi_interrupt` out 1: high while a frame is held and unread.
- `overrun` out 1: sticky; a completed frame was dropped.

## Operation
- All five inputs pass through 2-FF synchronizers; `i2s_bclk` and `rpi_clk` also get a third stage for rise/fall detect. `i2s_lrclk`/`i2s_sdin` are sampled only on a detected `i2s_bclk` rise.
- Capture FSM (advances only on bclk rise): WAIT_SYNC → DELAY → SHIFT.
  - WAIT_SYNC (after reset): wait for first lrclk falling transition (start of left), then DELAY. Data before this is discarded.
  - DELAY: the bclk rise that sees the lrclk change is the I2S one-bit delay slot; ignore data, clear bit counter, go SHIFT.
  - SHIFT: shift `i2s_sdin` into the channel register, count up. After `SAMPLE_WIDTH` bits, further bits ignored until lrclk changes. lrclk change → word closes (if fewer than `SAMPLE_WIDTH` bits, remaining LSBs zero-filled), channel swaps, counter clears; this rise is the next delay slot.
- Commit: when the right word closes (lrclk 1→0), {left,right} goes to the holding register if empty: holding_full=1. If full: frame dropped, holding unchanged, `overrun`=1 until reset.
- RPi readout:
  - `rpi_enable` rise with holding full → load 2×W shift reg with {left,right}; `rpi_serial` = bit 2W−1 immediately.
  - Each `rpi_clk` fall advances one bit (RPi samples on rise).
  - After 2W falls: holding_full=0, `rpi_interrupt`=0, `rpi_serial`=0.
  - `rpi_enable` fall mid-transfer: abort; holding stays full, interrupt stays high; next enable restarts from MSB.
  - Enable with holding empty: `rpi_serial` held 0, clocks ignored.
- Simultaneous commit and readout completion in one cycle: completion empties, commit refills; `rpi_interrupt` stays high, no overrun.
- Commit during an in-progress readout: holding full, so the frame drops and `overrun` sets.

## Timing
- Reset: `rpi_serial`=0, `rpi_interrupt`=0, `overrun`=0, FSM=WAIT_SYNC, holding empty, counters 0.
- Input-to-action: 3 `clk` cycles after a pin edge (2 sync + 1 detect).
- `rpi_interrupt` rises 1 `clk` after the commit cycle.
- `rpi_serial` updates 1 `clk` after the detected `rpi_clk` fall or `rpi_enable` rise.
- `rst` mid-capture or mid-readout: everything returns to reset values immediately. Capture resumes only at the next left-channel start.

## Structure
- Shared defines file `i2s_defs`: capture FSM state encodings, default `SAMPLE_WIDTH`, synchronizer depth.
- One sub-module, `edge_sync`: 3-FF synchronizer with `rise`/`fall` pulse outputs. Instantiated for `i2s_bclk` and `rpi_clk`. Plain 2-FF sync for the remaining inputs.
- Capture FSM, holding register and readout shifter stay in `i2s_rx_capture`.

## Test plan
- Frame capture: ADC model sends L=0xA5C3, R=0x1234 at bclk=`clk`/16 → `rpi_interrupt` high; a 32-clock readout returns 0xA5C31234 MSB first; interrupt low after the 32nd fall.
- Pre-sync garbage: start stream mid-right-word with R=0xFFFF, then full L=0x0001, R=0x0002 → first committed frame is 0x00010002.
- Overrun: two frames committed with no readout → `overrun`=1; readout returns the first frame.
- Abort: drop enable after 10 bits → interrupt stays 1; new enable returns the full frame from MSB.
- Short word: lrclk toggles after 12 bits of 0xABC → word captured as 0xABC0.
- Async reset mid-readout (bit 20) → all outputs 0 next cycle; the next frame is captured only after a fresh left-channel start.
